// File: rtl/soc_system_dipsw_pkg.sv
// Shared types for the DIP-switch PIO scanner: scan FSM states, PIO register
// offsets and the registered PIO bus request.
package soc_system_dipsw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_EDGE,
    RD_DATA,
    CAP_DATA,
    CLR,
    PUSH
  } scan_state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef struct packed {
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
  } pio_req_t;

  localparam pio_req_t PIO_REQ_IDLE = '{
    address:    PIO_ADDR_DATA,
    chipselect: 1'b0,
    write_n:    1'b1,
    writedata:  32'h0
  };

endpackage

// File: rtl/soc_system_dipsw_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted when
// a pop happens in the same cycle.
module soc_system_dipsw_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     empty_nxt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             cnt, cnt_nxt;
  logic                    empty_q;
  logic                    wr_en, rd_en;

  assign rd_en     = pop & ~empty_q;
  assign wr_en     = push & (~full | rd_en);
  assign cnt_nxt   = cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign empty_nxt = (cnt_nxt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt_nxt;
      empty_q <= empty_nxt;
    end
  end

  assign empty = empty_q;
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/soc_system_dipsw_scan_ctrl.sv
// Periodic DIP-switch PIO scanner: edge read, data read, edge clear, event push.
// Optional irq output when SOC_SYSTEM_DIPSW_SCAN_IRQ_EN is defined.
module soc_system_dipsw_scan_ctrl
  import soc_system_dipsw_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int POLL_CYCLES = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [1:0]         pio_address,
  output logic               pio_chipselect,
  output logic               pio_write_n,
  output logic [31:0]        pio_writedata,
  input  logic [31:0]        pio_readdata,
  input  logic               scan_req,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [2*WIDTH-1:0] evt_data,
  output logic               ovf,
  input  logic               ovf_clr
`ifdef SOC_SYSTEM_DIPSW_SCAN_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int              TW           = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_RELOAD = TW'(POLL_CYCLES - 1);
  localparam int              EW           = 2 * WIDTH;
  localparam int              CW           = $clog2(FIFO_DEPTH) + 1;

  scan_state_e      state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [WIDTH-1:0] mask_q, data_q;
  pio_req_t         bus_q, bus_nxt;
  logic             ovf_q, ovf_nxt;

  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty, fifo_empty_nxt;
  logic [CW-1:0]    fifo_count;
  logic [EW-1:0]    fifo_head;

  assign fifo_push = (state == PUSH);
  assign fifo_pop  = ~fifo_empty & evt_ready;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      IDLE: begin
        if (timer == '0 || scan_req) begin
          state_nxt = RD_EDGE;
          timer_nxt = TIMER_RELOAD;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      RD_EDGE:  state_nxt = RD_DATA;
      RD_DATA:  state_nxt = CAP_DATA;
      // mask_q was captured from the edge register at the end of RD_DATA
      CAP_DATA: state_nxt = (mask_q == '0) ? IDLE : CLR;
      CLR:      state_nxt = PUSH;
      PUSH:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Bus request is decoded from the next state so the registered outputs line
  // up with the state that owns them.
  always_comb begin
    bus_nxt = PIO_REQ_IDLE;
    unique case (state_nxt)
      RD_EDGE: begin
        bus_nxt.address    = PIO_ADDR_EDGE;
        bus_nxt.chipselect = 1'b1;
      end
      RD_DATA: begin
        bus_nxt.address    = PIO_ADDR_DATA;
        bus_nxt.chipselect = 1'b1;
      end
      CLR: begin
        bus_nxt.address    = PIO_ADDR_EDGE;
        bus_nxt.chipselect = 1'b1;
        bus_nxt.write_n    = 1'b0;
        bus_nxt.writedata  = {{(32-WIDTH){1'b0}}, mask_q};
      end
      default: bus_nxt = PIO_REQ_IDLE;
    endcase
  end

  always_comb begin
    ovf_nxt = ovf_q | (fifo_push & fifo_full & ~fifo_pop);
    if (ovf_clr) ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      timer  <= TIMER_RELOAD;
      bus_q  <= PIO_REQ_IDLE;
      mask_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      bus_q <= bus_nxt;
      ovf_q <= ovf_nxt;
      if (state == RD_DATA)  mask_q <= pio_readdata[WIDTH-1:0];
      if (state == CAP_DATA) data_q <= pio_readdata[WIDTH-1:0];
    end
  end

  soc_system_dipsw_evt_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({mask_q, data_q}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .empty_nxt (fifo_empty_nxt),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign pio_address    = bus_q.address;
  assign pio_chipselect = bus_q.chipselect;
  assign pio_write_n    = bus_q.write_n;
  assign pio_writedata  = bus_q.writedata;
  assign evt_valid      = ~fifo_empty;
  assign evt_data       = fifo_head;
  assign ovf            = ovf_q;

  logic unused_sig;
  assign unused_sig = ^{pio_readdata[31:WIDTH], fifo_count};

`ifdef SOC_SYSTEM_DIPSW_SCAN_IRQ_EN
  // Built from next-state values so irq tracks evt_valid/ovf without lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= ~fifo_empty_nxt | ovf_nxt;
  end
`else
  logic unused_irq;
  assign unused_irq = fifo_empty_nxt;
`endif

endmodule

// File: doc/soc_system_dipsw_scan_ctrl.md
# soc_system_dipsw_scan_ctrl

Periodic scanner that sequences the 4-bit DIP-switch PIO over its 2-bit-address slave port. Every scan it reads the edge-capture register, then reads the live switch data, then clears exactly the captured edge bits. Each scan with a non-zero edge mask produces one event {mask, data}, buffered in a small FIFO for software or fabric consumers. It sits between the PIO slave and the HPS-side event consumer, and is the only master of that PIO.

## Interface
Parameters:
- WIDTH, 4, switch/edge bit count; matches PIO in_port width.
- POLL_CYCLES, 50000, clocks between scan starts; legal range 8..2^24.
- FIFO_DEPTH, 4, event entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- pio_address  out  2  PIO register select (0 = data, 3 = edge capture).
- pio_chipselect  out  1  PIO select.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  32  write data; only bits [WIDTH-1:0] non-zero.
- pio_readdata  in  32  PIO registered read mux output.
- scan_req  in  1  single-cycle pulse requesting an immediate scan.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_data  out  2*WIDTH  {edge_mask, switch_data}.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.

## Operation
- The PIO readdata is registered from pio_address every clock. Read latency is exactly 1 cycle, with no waitrequest.
- FSM states and transitions:
  - IDLE: decrement timer.
    - Go to RD_EDGE when the timer reaches 0 or scan_req=1.
    - On leaving IDLE, reload the timer with POLL_CYCLES-1.
  - RD_EDGE: address=3, chipselect=1, write_n=1. Go to RD_DATA.
  - RD_DATA: address=0, chipselect=1. Latch mask = pio_readdata[WIDTH-1:0].
    - Go to CAP_DATA.
  - CAP_DATA: latch data = pio_readdata[WIDTH-1:0].
    - If mask==0, go to IDLE.
    - Otherwise go to CLR.
  - CLR: address=3, chipselect=1, write_n=0, writedata=mask. Go to PUSH.
  - PUSH: write {mask,data} to the FIFO if not full; otherwise set ovf. Go to IDLE.
- Bus outputs outside the states above: address=0, chipselect=0, write_n=1, writedata=0.
- scan_req outside IDLE is ignored; it is not queued.
- FIFO: first-word fall-through. A pop occurs when evt_valid && evt_ready.
  - A pop in the same cycle as a PUSH on a full FIFO frees the slot, and the push succeeds.
- ovf: ovf_clr has priority over a simultaneous set.
- Edge bits captured by the PIO after the RD_EDGE read are not in mask. They are not cleared, and they appear in the next scan.
- Reset mid-scan: FSM returns to IDLE, FIFO is emptied, timer is reloaded. No partial CLR write is issued.

## Timing
- Reset values:
  - pio_address=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
  - evt_valid=0, evt_data=0, ovf=0.
  - State IDLE; timer=POLL_CYCLES-1.
- First automatic scan starts POLL_CYCLES cycles after reset release.
- Scan length:
  - 3 cycles when mask==0.
  - 5 cycles when mask!=0.
- evt_valid rises the cycle after PUSH.
- Scan period is POLL_CYCLES+scan length when no scan_req occurs.
- All outputs are registered.

## Configuration
- SOC_SYSTEM_DIPSW_SCAN_IRQ_EN defined: adds output port irq (1 bit, registered).
  - irq=1 while the FIFO is non-empty or ovf=1.
  - Reset value 0.
- Not defined: the irq port and its logic are absent. Consumers poll evt_valid.

## Structure
- Shared package soc_system_dipsw_pkg holds:
  - state enum (IDLE, RD_EDGE, RD_DATA, CAP_DATA, CLR, PUSH);
  - register offsets PIO_ADDR_DATA=0 and PIO_ADDR_EDGE=3.
- One sub-module, soc_system_dipsw_evt_fifo:
  - parameterised width 2*WIDTH and depth FIFO_DEPTH;
  - push/pop, full/empty, count.
- FSM and timer live in the top level.

## Test plan
- Reset, no switch activity, POLL_CYCLES=16 → scan starts at cycle 16. Bus performs a read at address 3 then a read at address 0, with no write. evt_valid stays 0.
- in_port goes 0x0→0x5 → next scan:
  - CLR writes 0x5 to address 3;
  - event evt_data={0x5,0x5};
  - the edge register reads 0 on the following scan.
- scan_req pulse mid-IDLE with pending edge 0x8 → RD_EDGE the next cycle, and the event appears within 5 cycles. A scan_req during CLR is ignored.
- evt_ready held 0 with FIFO_DEPTH=4 and 5 edge-producing scans → 4 events retained in order and ovf=1. ovf_clr → ovf=0. Then drain → evt_valid=0.
- Full FIFO with evt_ready=1 in the PUSH cycle → no overflow, count stays 4.
- Assert reset_n low during CLR → the write is not completed, outputs return to reset values, and the FIFO is empty. SOC_SYSTEM_DIPSW_SCAN_IRQ_EN build: irq follows FIFO non-empty.
